// File: rtl/egress_replicator_if.sv
// Valid/ready packet bus: a destination port mask plus a flat header vector.
interface egress_replicator_if #(
  parameter int NUM_PORTS   = 4,
  parameter int HDR_MAX_LEN = 64
);
  logic                       valid;
  logic                       ready;
  logic [NUM_PORTS-1:0]       port;
  logic [HDR_MAX_LEN*8-1:0]   pkt_hdr;

  modport master (output valid, port, pkt_hdr, input ready);
  modport slave  (input valid, port, pkt_hdr, output ready);
endinterface

// File: rtl/egress_replicator.sv
// Egress replicator: queues packets from the traffic manager and emits one
// single-port copy per destination bit, lowest port first, in arrival order.
module egress_replicator #(
  parameter int NUM_PORTS   = 4,
  parameter int HDR_MAX_LEN = 64,
  parameter int DEPTH       = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  egress_replicator_if.slave       in_if,
  egress_replicator_if.master      out_if,
  output logic                     out_last,
  output logic [15:0]              drop_cnt,
  output logic [$clog2(DEPTH):0]   q_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int HW = HDR_MAX_LEN * 8;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

  logic [HW-1:0]        r_hdr_mem  [DEPTH];
  logic [NUM_PORTS-1:0] r_mask_mem [DEPTH];
  logic [AW-1:0]        r_head;
  logic [AW-1:0]        r_tail;
  logic [AW:0]          r_count;
  logic [NUM_PORTS-1:0] r_rem;
  logic [15:0]          r_drop;

  logic                 w_nonempty;
  logic                 w_in_ready;
  logic                 w_accept;
  logic                 w_push;
  logic                 w_drop;
  logic                 w_fire;
  logic                 w_pop;
  logic                 w_last;
  logic [NUM_PORTS-1:0] w_low;
  logic [NUM_PORTS-1:0] w_rem_next;
  logic [AW-1:0]        w_head_next;

  assign w_nonempty  = (r_count != '0);
  // Gated by reset so the upstream never sees ready while reset is held.
  assign w_in_ready  = rst && (r_count != FULL_CNT);
  assign w_accept    = in_if.valid && w_in_ready;
  assign w_push      = w_accept && (|in_if.port);
  assign w_drop      = w_accept && !(|in_if.port);
  assign w_low       = r_rem & (~r_rem + NUM_PORTS'(1));
  assign w_last      = ((r_rem & (r_rem - NUM_PORTS'(1))) == '0);
  assign w_fire      = w_nonempty && out_if.ready;
  assign w_pop       = w_fire && w_last;
  assign w_head_next = r_head + AW'(1);

  assign in_if.ready    = w_in_ready;
  assign out_if.valid   = w_nonempty;
  assign out_if.port    = w_nonempty ? w_low : '0;
  assign out_if.pkt_hdr = w_nonempty ? r_hdr_mem[r_head] : '0;
  assign out_last       = w_nonempty && w_last;
  assign drop_cnt       = r_drop;
  assign q_count        = r_count;

  // The remaining mask follows the head entry; on a pop it is refilled from the
  // next stored entry, or from the incoming packet if that one becomes head.
  always_comb begin
    w_rem_next = r_rem;
    if (w_pop) begin
      if (r_count > ONE_CNT) begin
        w_rem_next = r_mask_mem[w_head_next];
      end else if (w_push) begin
        w_rem_next = in_if.port;
      end else begin
        w_rem_next = '0;
      end
    end else if (w_fire) begin
      w_rem_next = r_rem & ~w_low;
    end else if (w_push && !w_nonempty) begin
      w_rem_next = in_if.port;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_hdr_mem[r_tail]  <= in_if.pkt_hdr;
      r_mask_mem[r_tail] <= in_if.port;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_rem   <= '0;
      r_drop  <= '0;
    end else begin
      r_rem <= w_rem_next;
      if (w_push) r_tail <= r_tail + AW'(1);
      if (w_pop)  r_head <= w_head_next;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + ONE_CNT;
        2'b01:   r_count <= r_count - ONE_CNT;
        default: r_count <= r_count;
      endcase
      if (w_drop && (r_drop != '1)) r_drop <= r_drop + 16'd1;
    end
  end

endmodule

// File: tb/tb_egress_replicator.sv
// Scoreboard bench for egress_replicator: a queue-of-copies model predicts
// every output copy, occupancy, ready and drop count from accepted packets.
module tb_egress_replicator;

  localparam int NP    = 4;
  localparam int HL    = 64;
  localparam int HW    = HL * 8;
  localparam int DEPTH = 4;

  typedef struct {
    logic [NP-1:0] port;
    logic [HW-1:0] hdr;
    logic          last;
  } copy_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        out_last;
  logic [15:0] drop_cnt;
  logic [2:0]  q_count;

  egress_replicator_if #(.NUM_PORTS(NP), .HDR_MAX_LEN(HL)) in_if ();
  egress_replicator_if #(.NUM_PORTS(NP), .HDR_MAX_LEN(HL)) out_if ();

  egress_replicator #(.NUM_PORTS(NP), .HDR_MAX_LEN(HL), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_if    (in_if),
    .out_if   (out_if),
    .out_last (out_last),
    .drop_cnt (drop_cnt),
    .q_count  (q_count)
  );

  always #5 clk = ~clk;

  copy_t       exp_q[$];
  int          m_cnt  = 0;
  int unsigned m_drop = 0;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic chk(input string name, input logic [HW-1:0] act, input logic [HW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [HW-1:0] rand_hdr();
    logic [HW-1:0] h;
    for (int i = 0; i < HW / 32; i++) h[i*32 +: 32] = $urandom;
    return h;
  endfunction

  // Model of one accepted packet: a copy per set bit, ascending, last on the top bit.
  task automatic model_accept(input logic [NP-1:0] mask, input logic [HW-1:0] hdr);
    copy_t c;
    logic [NP-1:0] above;
    if (mask == '0) begin
      if (m_drop < 32'hFFFF) m_drop++;
    end else begin
      m_cnt++;
      for (int i = 0; i < NP; i++) begin
        if (mask[i]) begin
          above  = mask >> (i + 1);
          c.port = NP'(1) << i;
          c.hdr  = hdr;
          c.last = (above == '0);
          exp_q.push_back(c);
        end
      end
    end
  endtask

  // Monitor: inputs and outputs are stable at the falling edge; compare against
  // the model, then advance the model by what the coming rising edge will do.
  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_out_valid", HW'(out_if.valid), '0);
      chk("rst_out_port", HW'(out_if.port), '0);
      chk("rst_out_last", HW'(out_last), '0);
      chk("rst_out_hdr", out_if.pkt_hdr, '0);
      chk("rst_in_ready", HW'(in_if.ready), '0);
      chk("rst_q_count", HW'(q_count), '0);
      chk("rst_drop_cnt", HW'(drop_cnt), '0);
      exp_q.delete();
      m_cnt  = 0;
      m_drop = 0;
    end else begin
      automatic int pre_cnt = m_cnt;
      chk("in_ready", HW'(in_if.ready), HW'(pre_cnt < DEPTH));
      chk("q_count", HW'(q_count), HW'(pre_cnt));
      chk("drop_cnt", HW'(drop_cnt), HW'(m_drop));
      chk("out_valid", HW'(out_if.valid), HW'(pre_cnt != 0));
      if (pre_cnt != 0) begin
        if (exp_q.size() == 0) begin
          chk("scoreboard_underrun", HW'(1), HW'(0));
        end else begin
          chk("out_port", HW'(out_if.port), HW'(exp_q[0].port));
          chk("out_hdr", out_if.pkt_hdr, exp_q[0].hdr);
          chk("out_last", HW'(out_last), HW'(exp_q[0].last));
          if (out_if.ready) begin
            if (exp_q[0].last) m_cnt--;
            void'(exp_q.pop_front());
          end
        end
      end
      if (in_if.valid && (pre_cnt < DEPTH)) model_accept(in_if.port, in_if.pkt_hdr);
    end
  end

  task automatic send(input logic [NP-1:0] mask, input logic [HW-1:0] hdr);
    bit acc = 0;
    in_if.valid   = 1'b1;
    in_if.port    = mask;
    in_if.pkt_hdr = hdr;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_if.ready) begin
        acc = 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    in_if.valid = 1'b0;
    if (!acc) chk("send_timeout", HW'(0), HW'(1));
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 500; i++) begin
      if (exp_q.size() == 0 && m_cnt == 0) break;
      @(posedge clk);
    end
    @(posedge clk);
    #1;
    chk(name, HW'(exp_q.size()), HW'(0));
  endtask

  initial begin
    #1_200_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [HW-1:0] h;
    logic          seq [4];
    bit            acc;

    rst            = 1'b0;
    in_if.valid    = 1'b0;
    in_if.port     = '0;
    in_if.pkt_hdr  = '0;
    out_if.ready   = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;

    // Unicast, header byte 0 = AA
    out_if.ready = 1'b1;
    h = rand_hdr();
    h[7:0] = 8'hAA;
    send(4'b0100, h);
    drain("unicast_drain");

    // Multicast with out_ready pattern 1,0,1,1
    out_if.ready = 1'b0;
    send(4'b1011, rand_hdr());
    seq[0] = 1'b1; seq[1] = 1'b0; seq[2] = 1'b1; seq[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      out_if.ready = seq[i];
      @(posedge clk); #1;
    end
    drain("multicast_drain");

    // Zero-mask drops
    for (int i = 0; i < 3; i++) send('0, rand_hdr());
    drain("drop_drain");

    // Fill to DEPTH with one extra held back, three rounds across pointer wrap
    for (int r = 0; r < 3; r++) begin
      out_if.ready = 1'b0;
      for (int i = 0; i < 4; i++) send(NP'(1) << ((i + r) % NP), rand_hdr());
      fork
        send(NP'(1) << r, rand_hdr());
        begin
          repeat (4) @(posedge clk);
          #1 out_if.ready = 1'b1;
        end
      join
      drain("full_wrap_drain");
    end

    // Push and pop in the same cycle at occupancy 2
    out_if.ready = 1'b0;
    send(4'b0001, rand_hdr());
    send(4'b0010, rand_hdr());
    fork
      send(4'b1000, rand_hdr());
      out_if.ready = 1'b1;
    join
    drain("pushpop_drain");

    // Randomised traffic with random backpressure
    acc = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk); #1;
      out_if.ready = ($urandom_range(3) != 0);
      if (!in_if.valid || acc) begin
        if ($urandom_range(2) == 0) begin
          in_if.valid   = 1'b1;
          in_if.port    = NP'($urandom_range(15));
          in_if.pkt_hdr = rand_hdr();
        end else begin
          in_if.valid = 1'b0;
        end
      end
      @(negedge clk);
      acc = in_if.valid && in_if.ready;
    end
    @(posedge clk); #1;
    in_if.valid  = 1'b0;
    out_if.ready = 1'b1;
    drain("random_drain");

    // Reset during the second copy of a 4-port packet with 3 more queued
    out_if.ready = 1'b0;
    send(4'b1111, rand_hdr());
    send(4'b0001, rand_hdr());
    send(4'b0010, rand_hdr());
    send(4'b0100, rand_hdr());
    out_if.ready = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrst_out_valid", HW'(out_if.valid), '0);
    chk("midrst_out_port", HW'(out_if.port), '0);
    chk("midrst_out_last", HW'(out_last), '0);
    chk("midrst_out_hdr", out_if.pkt_hdr, '0);
    chk("midrst_q_count", HW'(q_count), '0);
    chk("midrst_in_ready", HW'(in_if.ready), '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("postrst_out_valid", HW'(out_if.valid), '0);
    chk("postrst_q_count", HW'(q_count), '0);
    chk("postrst_in_ready", HW'(in_if.ready), HW'(1));
    repeat (3) @(posedge clk);
    #1;

    // Drop counter saturation
    in_if.valid = 1'b1;
    in_if.port  = '0;
    repeat (65540) @(posedge clk);
    #1 in_if.valid = 1'b0;
    @(negedge clk);
    chk("drop_saturate", HW'(drop_cnt), HW'(16'hFFFF));
    send('0, rand_hdr());
    @(negedge clk);
    chk("drop_saturate_hold", HW'(drop_cnt), HW'(16'hFFFF));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/egress_replicator.md
EGRESS_REPLICATOR -- requirements
Module: egress_replicator

Interface
REQ-001 Parameter NUM_PORTS, default 4, number of egress ports (width of port masks).
REQ-002 Parameter HDR_MAX_LEN, default 64, header bytes per packet.
REQ-003 Parameter DEPTH, default 4, header FIFO entries; SHALL be a power of two, at least 2.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 in_valid  input  1  upstream (tm stage) presents a packet.
REQ-007 in_ready  output  1  block accepts a packet this cycle.
REQ-008 in_out_port  input  NUM_PORTS  egress port bitmask from tm; multiple bits = multicast.
REQ-009 in_pkt_hdr  input  HDR_MAX_LEN x 8  header bytes from tm.
REQ-010 out_valid  output  1  a single-port copy is presented.
REQ-011 out_ready  input  1  downstream accepts the copy.
REQ-012 out_port  output  NUM_PORTS  one-hot destination of the current copy.
REQ-013 out_pkt_hdr  output  HDR_MAX_LEN x 8  header of the current copy.
REQ-014 out_last  output  1  current copy is the final copy of its packet.
REQ-015 drop_cnt  output  16  count of packets discarded for an all-zero port mask.
REQ-016 q_count  output  $clog2(DEPTH)+1  FIFO occupancy.

Function
REQ-017 Input handshake: accept when in_valid && in_ready; in_ready = (q_count < DEPTH), registered-state only, no dependence on out_ready (no full-FIFO bypass).
REQ-018 Accepted packet with in_out_port == 0 SHALL NOT be written; drop_cnt increments by 1, saturating at 16'hFFFF.
REQ-019 Accepted packet with nonzero mask SHALL be written to FIFO tail (header + mask); q_count +1.
REQ-020 Latency: packet accepted at edge N SHALL be presentable (out_valid=1) no earlier than after edge N; no combinational path from in_* to out_*.
REQ-021 Head state: register rem_mask holds not-yet-sent ports of the head entry; loaded with the entry's mask when it becomes head.
REQ-022 out_valid = FIFO non-empty; out_port = lowest set bit of rem_mask; out_pkt_hdr = head header; out_last = (rem_mask has exactly one bit set).
REQ-023 Output copy completes on out_valid && out_ready: clear out_port bit in rem_mask; if out_last, pop head, q_count -1, rem_mask loads the next entry's mask (same edge) or 0 if empty.
REQ-024 While out_valid && !out_ready, out_port, out_pkt_hdr, out_last SHALL hold stable.
REQ-025 Copies of one packet emitted in ascending port index; packets emitted in arrival order; no interleaving of copies from different packets.
REQ-026 Simultaneous push and pop in one cycle: both take effect; q_count unchanged; pointers wrap modulo DEPTH.
REQ-027 Push into empty FIFO: entry becomes head and rem_mask loads its mask at the same edge.
REQ-028 Full (q_count == DEPTH): in_ready = 0; a pop that cycle does not admit input until next cycle.
REQ-029 Throughput: one copy per cycle with out_ready held 1; a packet with k ports occupies the output for exactly k handshake cycles.

Reset
REQ-030 While rst = 0 (asynchronously): FIFO pointers, q_count, rem_mask, drop_cnt = 0; out_valid = 0, out_port = 0, out_last = 0, out_pkt_hdr = all zero; in_ready = 0.
REQ-031 After rst rises, in_ready = 1 from the first clock edge; reset mid-replication discards all queued entries and remaining copies, no partial copy emitted afterward.

Verification
REQ-032 Unicast: mask 4'b0100, hdr[0]=8'hAA, out_ready=1 -> one copy next cycle, out_port=4'b0100, out_last=1, hdr[0]=8'hAA; q_count returns to 0.
REQ-033 Multicast with backpressure: mask 4'b1011, out_ready toggling 1,0,1,1 -> copies out_port 0001, 0010 (held one stall cycle), 1000; out_last only on 1000; 3 handshakes total.
REQ-034 Drop: 3 packets with mask 0 -> no out_valid, drop_cnt=3; preload drop_cnt path to 16'hFFFF then one more drop -> stays 16'hFFFF.
REQ-035 Full/wrap: out_ready=0, push 5 unicast packets -> first 4 accepted, in_ready=0, q_count=4; release out_ready -> 4 copies in order; repeat 3 times, ordering preserved across pointer wrap.
REQ-036 Simultaneous push/pop at q_count=2 -> q_count stays 2, new packet emitted after the existing two.
REQ-037 Reset mid-op: assert rst during second copy of a 4-port packet with 3 queued -> outputs zero immediately; after release out_valid=0, q_count=0, in_ready=1.
